mx_block_sequencer: RTL and testbench
=====================================

// Module: mx_block_sequencer
// PURPOSE
//  Job-level controller for the MX block PE array (Block_PE_wrapper). Accepts one job descriptor
//  (precision/FP modes, quantisation modes, K-block count), gates upstream A/B operand streams into
//  the PE for exactly K blocks, drains, pulses send_output, captures the quantised 8x8 result and
//  shared exponent into a holding register, and returns it on a valid/ready result port.
// PARAMETERS
//  KCNT_W     8  width of K-block count (max job = 2^KCNT_W-1 blocks)
//  DRAIN_CYC  4  cycles from last operand accept to send_output pulse (PE accumulate pipeline depth)
//  OUT_LAT    3  cycles from send_output pulse to valid PE Out/shared_exp_out
// PORTS
//  clk_i            in   1        clock
//  rst_i            in   1        synchronous reset, active-high
//  cfg_valid_i      in   1        job descriptor valid
//  cfg_ready_o      out  1        descriptor accepted when valid&ready
//  cfg_prec_i       in   2        prec_mode for job;  cfg_fp_i in 2: FP_mode
//  cfg_prec_quan_i  in   2        prec_mode_quan;     cfg_fp_quan_i in 2: FP_mode_quan
//  cfg_kblocks_i    in   KCNT_W   number of A/B block pairs to accumulate
//  a_src_valid_i    in   1        upstream A operand valid;  a_src_ready_o out 1: A accepted
//  b_src_valid_i    in   1        upstream B operand valid;  b_src_ready_o out 1: B accepted
//  pe_a_valid_o     out  1        to PE A_valid;  pe_a_ready_i in 1: PE A_ready
//  pe_b_valid_o     out  1        to PE B_valid;  pe_b_ready_i in 1: PE B_ready
//  pe_prec_o/pe_fp_o/pe_prec_quan_o/pe_fp_quan_o  out 2 each  latched job modes to PE
//  pe_send_output_o out  1        one-cycle pulse to PE send_output
//  pe_out_i         in   512      PE Out [0:7][0:7][7:0];  pe_shexp_i in 8: PE shared_exp_out
//  res_valid_o      out  1        result held valid;  res_ready_i in 1: consumer accept
//  res_data_o       out  512      captured Out;  res_shexp_o out 8: captured shared exponent
//  busy_o           out  1        state != IDLE;  job_err_o out 1: one-cycle pulse, kblocks==0 rejected
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except cfg_ready_o=1; counters, mode and result regs cleared.
//  States: IDLE -> FEED -> DRAIN -> FLUSH -> WAIT_OUT -> HOLD -> IDLE.
//  IDLE: cfg_ready_o=1. cfg_valid&kblocks!=0: latch modes+K, clear a_cnt/b_cnt, ->FEED.
//   cfg_valid&kblocks==0: consume descriptor, job_err_o=1 next cycle, stay IDLE.
//  FEED: pe_a_valid_o = a_src_valid_i & (a_cnt<K); a_src_ready_o = pe_a_ready_i & (a_cnt<K);
//   A accepted on pe_a_valid_o&pe_a_ready_i -> a_cnt++. B identical, independent counter b_cnt.
//   Combinational pass-through, zero added latency; A and B may be accepted in different cycles.
//   When a_cnt==K and b_cnt==K (incl. both final accepts in same cycle) -> DRAIN, timer=0.
//  DRAIN: no operand handshakes; after DRAIN_CYC cycles -> FLUSH.
//  FLUSH: pe_send_output_o=1 for exactly one cycle -> WAIT_OUT, timer=0.
//  WAIT_OUT: after OUT_LAT cycles sample pe_out_i/pe_shexp_i into result regs -> HOLD.
//  HOLD: res_valid_o=1, data stable until res_valid&res_ready; on accept -> IDLE (res_valid_o=0
//   next cycle). Next descriptor not accepted in the handshake cycle (cfg_ready_o only in IDLE).
//  pe_*mode outputs hold the latched job modes from cfg accept until next cfg accept; never change mid-job.
//  Counters saturate at K; handshakes outside FEED are blocked (src_ready=0, pe_valid=0).
//  Synchronous reset mid-job: abort immediately, return to reset values; no send_output, no result.
//  Timers sized $clog2(max(DRAIN_CYC,OUT_LAT)+1); DRAIN_CYC=0/OUT_LAT=0 legal (state lasts 1 cycle).
// STRUCTURE
//  Shared package mx_pkg: state enum seq_state_t, mode typedefs (prec_t, fp_t, 2b), OUT_W=512 constant.
//  Sub-module mx_operand_gate (one instance per operand): counter + valid/ready gating, params KCNT_W.
//  Top holds FSM, timer, mode latch, result holding register.
// TESTING
//  K=3, A/B always valid, PE always ready -> 3 accepts each in 3 cycles, send_output pulse exactly
//   DRAIN_CYC+1 cycles after last accept, res_valid OUT_LAT+1 cycles later with pe_out value sampled.
//  K=2, B valid 5 cycles after A, PE A_ready toggling -> a_cnt/b_cnt each stop at 2, no 3rd accept,
//   DRAIN entered only after 2nd B accept.
//  kblocks=0 -> cfg consumed, job_err_o pulse 1 cycle, busy_o stays 0, no PE valid.
//  HOLD with res_ready=0 for 10 cycles while pe_out_i changes -> res_data_o unchanged; cfg_ready_o=0.
//  rst_i asserted in FEED after 1 accept -> next cycle IDLE, cfg_ready_o=1, no send_output ever.
//  Back-to-back jobs with different modes (INT8 then FP4) -> pe mode outputs switch only at cfg accept.

Source files
------------

// File: rtl/mx_block_sequencer_pkg.sv
// mx_pkg: shared types for the MX block sequencer.
// FSM states, job mode typedefs, result widths, timer sizing helper.
package mx_pkg;

  localparam int OUT_W   = 512;
  localparam int SHEXP_W = 8;

  typedef logic [1:0] prec_t;
  typedef logic [1:0] fp_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_FLUSH,
    S_WAIT_OUT,
    S_HOLD
  } seq_state_t;

  typedef struct packed {
    prec_t prec;
    fp_t   fp;
    prec_t prec_quan;
    fp_t   fp_quan;
  } job_mode_t;

  // Timer wide enough to count the longer wait; never zero width.
  function automatic int tmr_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mx_block_sequencer_if.sv
// mx_block_sequencer_if: one valid/ready handshake leg.
// master drives valid / samples ready; slave the reverse.
interface mx_block_sequencer_if;

  logic valid;
  logic ready;

  modport master (output valid, input  ready);
  modport slave  (input  valid, output ready);

endinterface

// File: rtl/mx_block_sequencer_gate.sv
// mx_operand_gate: passes one operand stream to the PE for exactly K beats.
// Ports: clk_i/rst_i; i_en (feeding), i_clr (job start), i_k (beat limit);
//   up (slave, from source), dn (master, to PE); o_full_nxt (count hits K
//   after this cycle's accept).
module mx_operand_gate
  import mx_pkg::*;
#(
  parameter int KCNT_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic [KCNT_W-1:0] i_k,
  mx_block_sequencer_if.slave  up,
  mx_block_sequencer_if.master dn,
  output logic              o_full_nxt
);

  logic [KCNT_W-1:0] r_cnt;
  logic [KCNT_W-1:0] w_cnt_nxt;
  logic              w_room;
  logic              w_fire;

  // Zero-latency pass-through, closed once K beats are in.
  assign w_room   = r_cnt < i_k;
  assign dn.valid = i_en & w_room & up.valid;
  assign up.ready = i_en & w_room & dn.ready;
  assign w_fire   = dn.valid & dn.ready;

  // w_room guarantees no wrap past K.
  assign w_cnt_nxt  = r_cnt + KCNT_W'(w_fire);
  assign o_full_nxt = (w_cnt_nxt == i_k);

  always_ff @(posedge clk_i) begin
    if (rst_i || i_clr) r_cnt <= '0;
    else                r_cnt <= w_cnt_nxt;
  end

endmodule

// File: rtl/mx_block_sequencer.sv
// mx_block_sequencer: job controller for the MX block PE array.
// Ports: cfg_* job descriptor (valid/ready); a_src_*/b_src_* upstream
//   operands; pe_*_valid/ready to PE; pe_*mode latched job modes;
//   pe_send_output_o pulse; pe_out_i/pe_shexp_i PE result; res_* held
//   result (valid/ready); busy_o; job_err_o (kblocks==0 rejected).
module mx_block_sequencer
  import mx_pkg::*;
#(
  parameter int KCNT_W    = 8,
  parameter int DRAIN_CYC = 4,
  parameter int OUT_LAT   = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  prec_t              cfg_prec_i,
  input  fp_t                cfg_fp_i,
  input  prec_t              cfg_prec_quan_i,
  input  fp_t                cfg_fp_quan_i,
  input  logic [KCNT_W-1:0]  cfg_kblocks_i,
  input  logic               a_src_valid_i,
  output logic               a_src_ready_o,
  input  logic               b_src_valid_i,
  output logic               b_src_ready_o,
  output logic               pe_a_valid_o,
  input  logic               pe_a_ready_i,
  output logic               pe_b_valid_o,
  input  logic               pe_b_ready_i,
  output prec_t              pe_prec_o,
  output fp_t                pe_fp_o,
  output prec_t              pe_prec_quan_o,
  output fp_t                pe_fp_quan_o,
  output logic               pe_send_output_o,
  input  logic [OUT_W-1:0]   pe_out_i,
  input  logic [SHEXP_W-1:0] pe_shexp_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [OUT_W-1:0]   res_data_o,
  output logic [SHEXP_W-1:0] res_shexp_o,
  output logic               busy_o,
  output logic               job_err_o
);

  localparam int TMR_W = tmr_w(DRAIN_CYC, OUT_LAT);

  seq_state_t         r_state;
  seq_state_t         w_state_nxt;
  logic [TMR_W-1:0]   r_timer;
  logic [KCNT_W-1:0]  r_k;
  job_mode_t          r_mode;
  logic [OUT_W-1:0]   r_res;
  logic [SHEXP_W-1:0] r_shexp;
  logic               r_err;

  logic w_idle;
  logic w_feed;
  logic w_zero;
  logic w_start;
  logic w_a_full;
  logic w_b_full;
  logic w_drain_done;
  logic w_out_done;
  logic w_cap;

  mx_block_sequencer_if u_a_up ();
  mx_block_sequencer_if u_a_dn ();
  mx_block_sequencer_if u_b_up ();
  mx_block_sequencer_if u_b_dn ();

  assign u_a_up.valid  = a_src_valid_i;
  assign a_src_ready_o = u_a_up.ready;
  assign pe_a_valid_o  = u_a_dn.valid;
  assign u_a_dn.ready  = pe_a_ready_i;

  assign u_b_up.valid  = b_src_valid_i;
  assign b_src_ready_o = u_b_up.ready;
  assign pe_b_valid_o  = u_b_dn.valid;
  assign u_b_dn.ready  = pe_b_ready_i;

  assign w_idle  = (r_state == S_IDLE);
  assign w_feed  = (r_state == S_FEED);
  assign w_zero  = (cfg_kblocks_i == '0);
  assign w_start = w_idle & cfg_valid_i & ~w_zero;

  mx_operand_gate #(.KCNT_W(KCNT_W)) u_gate_a (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_en       (w_feed),
    .i_clr      (w_start),
    .i_k        (r_k),
    .up         (u_a_up),
    .dn         (u_a_dn),
    .o_full_nxt (w_a_full)
  );

  mx_operand_gate #(.KCNT_W(KCNT_W)) u_gate_b (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_en       (w_feed),
    .i_clr      (w_start),
    .i_k        (r_k),
    .up         (u_b_up),
    .dn         (u_b_dn),
    .o_full_nxt (w_b_full)
  );

  // A zero-length wait still occupies its state for one cycle.
  assign w_drain_done = (DRAIN_CYC == 0) ||
                        (int'(r_timer) == DRAIN_CYC - 1);
  assign w_out_done   = (OUT_LAT == 0) ||
                        (int'(r_timer) == OUT_LAT - 1);
  assign w_cap        = (r_state == S_WAIT_OUT) & w_out_done;

  always_comb begin
    w_state_nxt      = r_state;
    cfg_ready_o      = 1'b0;
    busy_o           = 1'b1;
    pe_send_output_o = 1'b0;
    res_valid_o      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        cfg_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (w_start) w_state_nxt = S_FEED;
      end
      S_FEED: begin
        if (w_a_full && w_b_full) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_drain_done) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        pe_send_output_o = 1'b1;
        w_state_nxt      = S_WAIT_OUT;
      end
      S_WAIT_OUT: begin
        if (w_out_done) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        res_valid_o = 1'b1;
        if (res_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Timer restarts on every state change.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= (w_state_nxt != r_state) ? '0 : r_timer + TMR_W'(1);
      r_err   <= w_idle & cfg_valid_i & w_zero;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_k    <= '0;
      r_mode <= '0;
    end else if (w_start) begin
      r_k    <= cfg_kblocks_i;
      r_mode <= {cfg_prec_i, cfg_fp_i,
                 cfg_prec_quan_i, cfg_fp_quan_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_res   <= '0;
      r_shexp <= '0;
    end else if (w_cap) begin
      r_res   <= pe_out_i;
      r_shexp <= pe_shexp_i;
    end
  end

  assign pe_prec_o      = r_mode.prec;
  assign pe_fp_o        = r_mode.fp;
  assign pe_prec_quan_o = r_mode.prec_quan;
  assign pe_fp_quan_o   = r_mode.fp_quan;
  assign res_data_o     = r_res;
  assign res_shexp_o    = r_shexp;
  assign job_err_o      = r_err;

endmodule

// File: tb/tb_mx_block_sequencer.sv
// tb_mx_block_sequencer: directed bench for mx_block_sequencer.
// Default parameters: KCNT_W=8, DRAIN_CYC=4, OUT_LAT=3.
module tb_mx_block_sequencer;
  import mx_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         cfg_valid, cfg_ready;
  logic [1:0]   cfg_prec, cfg_fp, cfg_pq, cfg_fq;
  logic [7:0]   cfg_k;
  logic         a_src_valid, a_src_ready, b_src_valid, b_src_ready;
  logic         pe_a_valid, pe_a_ready, pe_b_valid, pe_b_ready;
  logic [1:0]   pe_prec, pe_fp, pe_pq, pe_fq;
  logic         send;
  logic [511:0] pe_out;
  logic [7:0]   pe_shexp;
  logic         res_valid, res_ready;
  logic [511:0] res_data;
  logic [7:0]   res_shexp;
  logic         busy, job_err;

  mx_block_sequencer_if res_hs ();
  assign res_hs.valid = res_valid;
  assign res_hs.ready = res_ready;

  mx_block_sequencer dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .cfg_valid_i      (cfg_valid),
    .cfg_ready_o      (cfg_ready),
    .cfg_prec_i       (cfg_prec),
    .cfg_fp_i         (cfg_fp),
    .cfg_prec_quan_i  (cfg_pq),
    .cfg_fp_quan_i    (cfg_fq),
    .cfg_kblocks_i    (cfg_k),
    .a_src_valid_i    (a_src_valid),
    .a_src_ready_o    (a_src_ready),
    .b_src_valid_i    (b_src_valid),
    .b_src_ready_o    (b_src_ready),
    .pe_a_valid_o     (pe_a_valid),
    .pe_a_ready_i     (pe_a_ready),
    .pe_b_valid_o     (pe_b_valid),
    .pe_b_ready_i     (pe_b_ready),
    .pe_prec_o        (pe_prec),
    .pe_fp_o          (pe_fp),
    .pe_prec_quan_o   (pe_pq),
    .pe_fp_quan_o     (pe_fq),
    .pe_send_output_o (send),
    .pe_out_i         (pe_out),
    .pe_shexp_i       (pe_shexp),
    .res_valid_o      (res_valid),
    .res_ready_i      (res_ready),
    .res_data_o       (res_data),
    .res_shexp_o      (res_shexp),
    .busy_o           (busy),
    .job_err_o        (job_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge, checks 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [511:0] P0, P1, P2, P3;
  logic saw_send, saw_res;

  initial begin
    P0 = {64{8'hA5}};
    P1 = {16{32'h0123_4567}};
    P2 = {8{64'hDEAD_BEEF_CAFE_F00D}};
    P3 = {32{16'h5A3C}};
    rst = 1'b1;
    cfg_valid = 0; cfg_prec = 0; cfg_fp = 0; cfg_pq = 0; cfg_fq = 0;
    cfg_k = 0;
    a_src_valid = 0; b_src_valid = 0; pe_a_ready = 0; pe_b_ready = 0;
    pe_out = P0; pe_shexp = 0; res_ready = 0;
    cyc(); cyc();
    #1;
    chk("rst_cfg_ready", 512'(cfg_ready), 512'(1));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_res_valid", 512'(res_hs.valid), 512'(0));
    chk("rst_send", 512'(send), 512'(0));
    chk("rst_job_err", 512'(job_err), 512'(0));
    chk("rst_pe_a_valid", 512'(pe_a_valid), 512'(0));
    chk("rst_res_data", res_data, 512'(0));
    chk("rst_modes", 512'({pe_prec, pe_fp, pe_pq, pe_fq}), 512'(0));

    // Job 1: K=3, everything valid/ready, INT8-style modes.
    cyc();
    rst = 0;
    cfg_valid = 1; cfg_k = 8'd3;
    cfg_prec = 2'b00; cfg_fp = 2'b00; cfg_pq = 2'b01; cfg_fq = 2'b00;
    a_src_valid = 1; b_src_valid = 1; pe_a_ready = 1; pe_b_ready = 1;
    #1;
    chk("j1_idle_cfg_ready", 512'(cfg_ready), 512'(1));
    chk("j1_idle_no_pe_valid", 512'(pe_a_valid), 512'(0));
    cyc();
    cfg_valid = 0;
    #1;
    chk("j1_busy", 512'(busy), 512'(1));
    chk("j1_cfg_ready_low", 512'(cfg_ready), 512'(0));
    chk("j1_pq_latched", 512'(pe_pq), 512'(1));
    chk("j1_a_valid", 512'(pe_a_valid), 512'(1));
    chk("j1_b_valid", 512'(pe_b_valid), 512'(1));
    chk("j1_a_src_ready", 512'(a_src_ready), 512'(1));
    cyc();
    cyc();
    #1;
    chk("j1_third_accept", 512'(pe_a_valid), 512'(1));
    cyc();
    #1;
    chk("j1_drain_a_valid", 512'(pe_a_valid), 512'(0));
    chk("j1_drain_b_ready", 512'(b_src_ready), 512'(0));
    chk("j1_drain_send", 512'(send), 512'(0));
    cyc(); cyc(); cyc();
    #1;
    chk("j1_send_early", 512'(send), 512'(0));
    cyc();
    #1;
    chk("j1_send_pulse", 512'(send), 512'(1));
    cyc();
    #1;
    chk("j1_send_one_cycle", 512'(send), 512'(0));
    cyc();
    cyc();
    pe_out = P1; pe_shexp = 8'h7E;
    #1;
    chk("j1_res_valid_early", 512'(res_valid), 512'(0));
    cyc();
    pe_out = P2; pe_shexp = 8'h11;
    #1;
    chk("j1_res_valid", 512'(res_valid), 512'(1));
    chk("j1_res_data", res_data, P1);
    chk("j1_res_shexp", 512'(res_shexp), 512'(8'h7E));

    // Hold with consumer stalled while PE output keeps changing.
    for (int i = 0; i < 10; i++) begin
      cyc();
      pe_out = P2 ^ 512'(i + 1);
      pe_shexp = 8'(i);
      #1;
      chk("hold_data", res_data, P1);
      chk("hold_cfg_ready", 512'(cfg_ready), 512'(0));
    end
    cyc();
    res_ready = 1;
    #1;
    chk("hold_accept_valid", 512'(res_valid), 512'(1));
    chk("hold_accept_cfg_ready", 512'(cfg_ready), 512'(0));
    cyc();
    res_ready = 0;
    #1;
    chk("j1_done_valid", 512'(res_valid), 512'(0));
    chk("j1_done_cfg_ready", 512'(cfg_ready), 512'(1));
    chk("j1_done_busy", 512'(busy), 512'(0));

    // Job 2: K=2, FP4-style modes, B late, PE A_ready toggling.
    cyc();
    cfg_valid = 1; cfg_k = 8'd2;
    cfg_prec = 2'b10; cfg_fp = 2'b01; cfg_pq = 2'b10; cfg_fq = 2'b01;
    a_src_valid = 1; b_src_valid = 0; pe_a_ready = 1; pe_b_ready = 1;
    #1;
    chk("j2_modes_before_accept",
        512'({pe_prec, pe_fp, pe_pq, pe_fq}), 512'(8'b00_00_01_00));
    cyc();
    cfg_valid = 0;
    #1;
    chk("j2_modes_after_accept",
        512'({pe_prec, pe_fp, pe_pq, pe_fq}), 512'(8'b10_01_10_01));
    chk("j2_a1_valid", 512'(pe_a_valid), 512'(1));
    chk("j2_a1_src_ready", 512'(a_src_ready), 512'(1));
    chk("j2_b_idle", 512'(pe_b_valid), 512'(0));
    cyc();
    pe_a_ready = 0;
    #1;
    chk("j2_a_stall_valid", 512'(pe_a_valid), 512'(1));
    chk("j2_a_stall_ready", 512'(a_src_ready), 512'(0));
    cyc();
    pe_a_ready = 1;
    cyc();
    pe_a_ready = 0;
    cyc();
    pe_a_ready = 1;
    #1;
    chk("j2_a_sat_valid", 512'(pe_a_valid), 512'(0));
    chk("j2_a_sat_ready", 512'(a_src_ready), 512'(0));
    cyc();
    b_src_valid = 1;
    #1;
    chk("j2_b1_valid", 512'(pe_b_valid), 512'(1));
    chk("j2_b1_busy", 512'(busy), 512'(1));
    cyc();
    #1;
    chk("j2_b2_valid", 512'(pe_b_valid), 512'(1));
    cyc();
    #1;
    chk("j2_drain_b_valid", 512'(pe_b_valid), 512'(0));
    chk("j2_drain_b_ready", 512'(b_src_ready), 512'(0));
    cyc(); cyc(); cyc();
    #1;
    chk("j2_send_early", 512'(send), 512'(0));
    cyc();
    pe_out = P3; pe_shexp = 8'h22;
    #1;
    chk("j2_send_pulse", 512'(send), 512'(1));
    cyc(); cyc(); cyc();
    cyc();
    res_ready = 1;
    #1;
    chk("j2_res_valid", 512'(res_valid), 512'(1));
    chk("j2_res_data", res_data, P3);
    chk("j2_res_shexp", 512'(res_shexp), 512'(8'h22));
    cyc();
    res_ready = 0;
    #1;
    chk("j2_done_valid", 512'(res_valid), 512'(0));
    chk("j2_modes_held", 512'({pe_prec, pe_fp}), 512'(4'b10_01));

    // Zero-length job is consumed and flagged.
    cyc();
    cfg_valid = 1; cfg_k = 8'd0;
    cfg_prec = 2'b11; cfg_fp = 2'b11; cfg_pq = 2'b11; cfg_fq = 2'b11;
    #1;
    chk("k0_cfg_ready", 512'(cfg_ready), 512'(1));
    chk("k0_err_before", 512'(job_err), 512'(0));
    cyc();
    cfg_valid = 0;
    #1;
    chk("k0_err_pulse", 512'(job_err), 512'(1));
    chk("k0_busy", 512'(busy), 512'(0));
    chk("k0_no_pe_valid", 512'(pe_a_valid), 512'(0));
    chk("k0_modes_kept", 512'({pe_prec, pe_fp}), 512'(4'b10_01));
    cyc();
    #1;
    chk("k0_err_once", 512'(job_err), 512'(0));
    chk("k0_still_idle", 512'(cfg_ready), 512'(1));

    // Reset in FEED after one accept aborts the job.
    cyc();
    cfg_valid = 1; cfg_k = 8'd3;
    cfg_prec = 2'b01; cfg_fp = 2'b01; cfg_pq = 2'b01; cfg_fq = 2'b01;
    cyc();
    cfg_valid = 0;
    #1;
    chk("rj_a_valid", 512'(pe_a_valid), 512'(1));
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    #1;
    chk("rj_cfg_ready", 512'(cfg_ready), 512'(1));
    chk("rj_busy", 512'(busy), 512'(0));
    chk("rj_pe_a_valid", 512'(pe_a_valid), 512'(0));
    chk("rj_modes_cleared", 512'({pe_prec, pe_fp, pe_pq, pe_fq}), 512'(0));
    saw_send = 0;
    saw_res = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      #1;
      saw_send = saw_send | send;
      saw_res = saw_res | res_valid;
    end
    chk("rj_no_send", 512'(saw_send), 512'(0));
    chk("rj_no_result", 512'(saw_res), 512'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
